noc_ingress_buf: RTL and testbench
==================================

Name: noc_ingress_buf

Overview:
- Per-input ingress buffer feeding one input port of the M-to-N NoC switch.
- Accepts flits from a source over a req/rdy handshake and queues them in a FIFO.
- Extracts the destination port index from the tag and presents the head flit with its switch-select field (dn_swb_o).
- Drops flits with illegal destinations, flags each drop, and counts downstream stall cycles.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TAG_W, 32, flit tag width.
- OUT_N, 5, number of switch output ports; destinations 0..OUT_N-1 are legal.
- OUT_W, $clog2(OUT_N), width of the destination field.
- DST_LSB, 0, LSB of the destination field inside the tag; DST_LSB+OUT_W <= TAG_W.
- STALL_W, 16, stall counter width.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- upreq_i  input  1  upstream flit valid.
- uptag_i  input  TAG_W  upstream flit.
- uprdy_o  output  1  buffer can accept.
- dnreq_o  output  1  head flit valid to switch.
- dn_swb_o  output  OUT_W  destination port of the head flit.
- dntag_o  output  TAG_W  head flit.
- dnrdy_i  input  1  switch accepts.
- err_drop_o  output  1  one-cycle pulse when an illegal flit is dropped.
- stall_cnt_o  output  STALL_W  saturating count of cycles with dnreq_o=1 and dnrdy_i=0.
- count_o  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: one clock and one reset. On rst=1 at a clock edge, all of the following clear; rst has priority over any push or pop in that cycle:
  - wr_ptr, rd_ptr, count = 0
  - uprdy_o=0 during reset and 1 from the first cycle after reset
  - dnreq_o=0, err_drop_o=0, stall_cnt_o=0
  - dn_swb_o and dntag_o are don't-care while dnreq_o=0; they are driven from the storage at rd_ptr.
- Push: occurs when upreq_i && uprdy_o.
  - uprdy_o = (count != DEPTH), registered-state based, with no dependence on upreq_i.
- Pop: occurs when dnreq_o && dnrdy_i.
- Storage: DEPTH x TAG_W array. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Occupancy:
  - count increments on push-only, decrements on pop-only, and is unchanged on simultaneous push and pop.
  - At count==DEPTH no push occurs. A pop in that cycle frees a slot for the next cycle only.
- Latency: a pushed flit appears on dnreq_o no earlier than the next cycle. Minimum latency is 1 cycle unless the optional feature is enabled.
- Head decode:
  - head_dst = head_tag[DST_LSB +: OUT_W]
  - legal = (head_dst < OUT_N)
  - dnreq_o = (count != 0) && legal
  - dn_swb_o = head_dst
- Illegal head: when count != 0 and legal = 0:
  - the entry is popped internally that cycle, regardless of dnrdy_i
  - err_drop_o = 1 for that cycle (combinational from head state), else 0
  - consecutive illegal flits drain at one per cycle with a continuous err_drop_o
  - a simultaneous push is allowed and is counted as push+pop.
- Handshake rules:
  - Once dnreq_o=1 it holds, with stable dn_swb_o/dntag_o, until the pop.
  - dnrdy_i may toggle freely; no combinational path from dnrdy_i to uprdy_o.
- Stall counter: increments each cycle with dnreq_o && !dnrdy_i and saturates at 2^STALL_W-1. It never clears except on rst.

Optional Feature:
- Macro: NOC_INGRESS_BYPASS_EN.
- Defined: when count==0 and upreq_i=1, the incoming flit drives dnreq_o/dn_swb_o/dntag_o combinationally in the same cycle.
  - If legal and dnrdy_i=1, it passes with zero latency and is never written to the FIFO; count is unchanged.
  - If dnrdy_i=0, it is pushed normally.
  - If illegal, err_drop_o pulses and the flit is not stored.
  - uprdy_o is unchanged (1 when not full).
- Undefined: no upstream-to-downstream combinational path; minimum latency is 1 cycle.

Decomposition:
- Shared NoC package holds:
  - typedef noc_tag_t (logic [TAG_W-1:0]) and the destination-field extraction function, with TAG_W, OUT_N, DST_LSB as package constants.
  - the ingress counter width constant.
- One sub-module is natural: noc_fifo_core (storage, pointers, count, full/empty). noc_ingress_buf adds the head decode, drop, bypass and stall logic around it.

Test Plan:
- Reset, then push tags 0x0000_0001..0x0000_0004 (dst 1..4) with dnrdy_i=0:
  - count_o reaches 4, uprdy_o=0, stall_cnt_o increments each cycle
  - release dnrdy_i: flits exit in order with dn_swb_o=1,2,3,4.
- Full FIFO with simultaneous upreq_i and dnrdy_i=1: no push in the full cycle; push accepted the next cycle; count_o goes 4->3->3.
- Push tag 0x0000_0007 (dst 7 >= OUT_N=5) then 0x0000_0002:
  - err_drop_o pulses one cycle, dnreq_o stays 0 during the drop
  - next flit presents with dn_swb_o=2.
- Random dnrdy_i toggling, 1000 flits: dntag_o stays stable while dnreq_o && !dnrdy_i; output order equals input order; no loss or duplication.
- Assert rst mid-traffic with count_o=3 and a simultaneous push/pop: next cycle count_o=0, dnreq_o=0, stall_cnt_o=0; buffer resumes cleanly.
- With NOC_INGRESS_BYPASS_EN defined, empty FIFO, dnrdy_i=1, push 0x0000_0003: dnreq_o=1 and dn_swb_o=3 in the same cycle, count_o stays 0. Without the macro, dnreq_o rises one cycle later.

Source files
------------

// File: rtl/noc_ingress_buf_pkg.sv
// Shared NoC definitions: flit tag type, destination-field layout and ingress counter width.
package noc_ingress_buf_pkg;

    localparam int unsigned NOC_TAG_W   = 32;
    localparam int unsigned NOC_OUT_N   = 5;
    localparam int unsigned NOC_OUT_W   = $clog2(NOC_OUT_N);
    localparam int unsigned NOC_DST_LSB = 0;
    localparam int unsigned NOC_DEPTH   = 4;
    localparam int unsigned NOC_STALL_W = 16;
    localparam int unsigned NOC_CNT_W   = $clog2(NOC_DEPTH) + 1;

    typedef logic [NOC_TAG_W-1:0] noc_tag_t;

    function automatic logic [NOC_OUT_W-1:0] noc_dst(input noc_tag_t tag);
        return tag[NOC_DST_LSB +: NOC_OUT_W];
    endfunction

endpackage

// File: rtl/noc_fifo_core.sv
// Circular FIFO: storage, wrapping pointers and occupancy count. Push/pop are pre-qualified
// by the caller; rst wins over both.
module noc_fifo_core
    import noc_ingress_buf_pkg::*;
#(
    parameter int unsigned DEPTH = NOC_DEPTH,
    parameter int unsigned WIDTH = NOC_TAG_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage carries no reset; contents are only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/noc_ingress_buf.sv
// Ingress buffer for one switch input: queues flits, decodes the head destination, drops
// illegal destinations and counts stall cycles. Define NOC_INGRESS_BYPASS_EN for zero-latency
// pass-through when the buffer is empty.
module noc_ingress_buf
    import noc_ingress_buf_pkg::*;
#(
    parameter int unsigned DEPTH   = NOC_DEPTH,
    parameter int unsigned TAG_W   = NOC_TAG_W,
    parameter int unsigned OUT_N   = NOC_OUT_N,
    parameter int unsigned OUT_W   = $clog2(OUT_N),
    parameter int unsigned DST_LSB = NOC_DST_LSB,
    parameter int unsigned STALL_W = NOC_STALL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     upreq_i,
    input  logic [TAG_W-1:0]         uptag_i,
    output logic                     uprdy_o,
    output logic                     dnreq_o,
    output logic [OUT_W-1:0]         dn_swb_o,
    output logic [TAG_W-1:0]         dntag_o,
    input  logic                     dnrdy_i,
    output logic                     err_drop_o,
    output logic [STALL_W-1:0]       stall_cnt_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    // One spare bit so OUT_N itself is representable when it is a power of two.
    localparam int unsigned CMP_W = OUT_W + 1;

    logic [TAG_W-1:0]   head_tag;
    logic [CNT_W-1:0]   count;
    logic               full, empty;
    logic               push, pop;
    logic [OUT_W-1:0]   head_dst, in_dst;
    logic               head_legal, in_legal;
    logic               head_drop;
    logic [STALL_W-1:0] stall_q;

    noc_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH (TAG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (uptag_i),
        .rdata (head_tag),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        head_dst   = head_tag[DST_LSB +: OUT_W];
        in_dst     = uptag_i[DST_LSB +: OUT_W];
        head_legal = ({1'b0, head_dst} < CMP_W'(OUT_N));
        in_legal   = ({1'b0, in_dst} < CMP_W'(OUT_N));
    end

    // Ready depends only on registered occupancy and reset, never on dnrdy_i or upreq_i.
    assign uprdy_o   = !full && !rst;
    assign head_drop = !empty && !head_legal;
    assign pop       = (!empty && head_legal && dnrdy_i) || head_drop;

    always_comb begin
        dnreq_o    = !empty && head_legal;
        dn_swb_o   = head_dst;
        dntag_o    = head_tag;
        err_drop_o = head_drop;
        push       = upreq_i && uprdy_o;
`ifdef NOC_INGRESS_BYPASS_EN
        // Empty buffer: present the incoming flit directly; store it only if it must wait.
        if (empty && upreq_i && uprdy_o) begin
            dnreq_o    = in_legal;
            dn_swb_o   = in_dst;
            dntag_o    = uptag_i;
            err_drop_o = !in_legal;
            push       = in_legal && !dnrdy_i;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (dnreq_o && !dnrdy_i && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_q;
    assign count_o     = count;

endmodule

// File: tb/tb_noc_ingress_buf.sv
// Randomized self-checking bench for noc_ingress_buf against a queue-based reference model.
module tb_noc_ingress_buf;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TAG_W   = 32;
    localparam int unsigned OUT_N   = 5;
    localparam int unsigned OUT_W   = 3;
    localparam int unsigned STALL_W = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 upreq_i;
    logic [TAG_W-1:0]     uptag_i;
    logic                 uprdy_o;
    logic                 dnreq_o;
    logic [OUT_W-1:0]     dn_swb_o;
    logic [TAG_W-1:0]     dntag_o;
    logic                 dnrdy_i;
    logic                 err_drop_o;
    logic [STALL_W-1:0]   stall_cnt_o;
    logic [2:0]           count_o;

    noc_ingress_buf u_dut (
        .clk         (clk),
        .rst         (rst),
        .upreq_i     (upreq_i),
        .uptag_i     (uptag_i),
        .uprdy_o     (uprdy_o),
        .dnreq_o     (dnreq_o),
        .dn_swb_o    (dn_swb_o),
        .dntag_o     (dntag_o),
        .dnrdy_i     (dnrdy_i),
        .err_drop_o  (err_drop_o),
        .stall_cnt_o (stall_cnt_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: FIFO of accepted flits plus the stall count.
    logic [TAG_W-1:0] model_q [$];
    int unsigned      m_stall = 0;
    logic             hold_prev = 1'b0;
    logic [TAG_W-1:0] prev_tag = '0;
    int unsigned      n_in_legal = 0;
    int unsigned      n_out = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int unsigned dst_of(input logic [TAG_W-1:0] tag);
        return int'(tag % 8);
    endfunction

    function automatic logic is_legal(input logic [TAG_W-1:0] tag);
        return dst_of(tag) < OUT_N;
    endfunction

    // One clock cycle: drive, check outputs before the edge, then advance the model.
    task automatic step(input logic req, input logic [TAG_W-1:0] tag, input logic rdy,
                        input logic r);
        logic             exp_rdy, exp_req, exp_err, byp;
        logic [TAG_W-1:0] exp_tag;
        int unsigned      sz;
        @(negedge clk);
        rst     = r;
        upreq_i = req;
        uptag_i = tag;
        dnrdy_i = rdy;
        #1;
        sz      = model_q.size();
        exp_rdy = !r && (sz < DEPTH);
        exp_req = 1'b0;
        exp_err = 1'b0;
        exp_tag = '0;
        byp     = 1'b0;
        if (sz > 0) begin
            exp_tag = model_q[0];
            exp_req = is_legal(exp_tag);
            exp_err = !exp_req;
        end
`ifdef NOC_INGRESS_BYPASS_EN
        else if (req && exp_rdy) begin
            byp     = 1'b1;
            exp_tag = tag;
            exp_req = is_legal(tag);
            exp_err = !exp_req;
        end
`endif
        check("count", 64'(count_o), 64'(sz));
        check("uprdy", 64'(uprdy_o), 64'(exp_rdy));
        check("dnreq", 64'(dnreq_o), 64'(exp_req));
        check("err_drop", 64'(err_drop_o), 64'(exp_err));
        check("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
        if (exp_req) begin
            check("dntag", 64'(dntag_o), 64'(exp_tag));
            check("dn_swb", 64'(dn_swb_o), 64'(dst_of(exp_tag)));
        end
        if (hold_prev && !r) begin
            check("stable", 64'(dntag_o), 64'(prev_tag));
        end
        if (req && uprdy_o && is_legal(tag)) n_in_legal++;
        if (dnreq_o && dnrdy_i) n_out++;
        @(posedge clk);
        hold_prev = !r && exp_req && !rdy;
        prev_tag  = exp_tag;
        if (r) begin
            model_q.delete();
            m_stall = 0;
        end else begin
            if (exp_req && !rdy && m_stall != (1 << STALL_W) - 1) m_stall++;
            if (byp) begin
                if (exp_req && !rdy) model_q.push_back(tag);
            end else begin
                if (sz > 0 && (exp_err || rdy)) void'(model_q.pop_front());
                if (req && exp_rdy) model_q.push_back(tag);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && model_q.size() > 0; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [TAG_W-1:0] t;
        int unsigned      sent, cyc;
        rst     = 1'b1;
        upreq_i = 1'b0;
        uptag_i = '0;
        dnrdy_i = 1'b0;
        repeat (2) @(posedge clk);

        // Fill with dst 1..4 while downstream stalls, then release in order.
        for (int i = 1; i <= 4; i++) step(1'b1, TAG_W'(i), 1'b0, 1'b0);
        step(1'b1, 32'h0000_0009, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        // Full buffer with simultaneous push and pop: 4 -> 3 -> 3.
        for (int i = 1; i <= 4; i++) step(1'b1, 32'h100 + TAG_W'(i), 1'b0, 1'b0);
        step(1'b1, 32'h0000_0201, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0202, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();

        // Illegal destination followed by a legal one.
        step(1'b1, 32'h0000_0007, 1'b1, 1'b0);
        step(1'b1, 32'h0000_0002, 1'b1, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        drain();
        step(1'b1, 32'h0000_0006, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0005, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0003, 1'b0, 1'b0);
        drain();

        // Random traffic with toggling dnrdy_i.
        n_in_legal = 0;
        n_out      = 0;
        sent       = 0;
        cyc        = 0;
        while (sent < 1000 && cyc < 20000) begin
            logic req;
            req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) t = ($urandom & 32'hFFFF_FFF8) | 32'(5 + $urandom_range(0, 2));
            else t = ($urandom & 32'hFFFF_FFF8) | 32'($urandom_range(0, OUT_N - 1));
            if (req && model_q.size() < DEPTH) sent++;
            step(req, t, 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
        end
        check("random_sent", 64'(sent), 64'd1000);
        drain();
        check("no_loss", 64'(n_out), 64'(n_in_legal));

        // Reset mid-traffic with count 3 and a simultaneous push/pop.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0301 + TAG_W'(i), 1'b0, 1'b0);
        step(1'b1, 32'h0000_0304, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_stall", 64'(stall_cnt_o), 64'd0);
        step(1'b1, 32'h0000_0401, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0402, 1'b1, 1'b0);
        drain();

        // Empty buffer, push dst 3 with downstream ready.
        step(1'b1, 32'h0000_0003, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 32'h0000_000F, 1'b1, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
